// File: rtl/riscv_mc_if.sv
// Unified instruction/data memory port: the core drives a registered request, the memory answers with ready/rdata.
// An access completes in any cycle where req and ready are both high; ready with req low is ignored.
interface riscv_mc_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/riscv_mc.sv
// Multi-cycle RV32I-subset core on one shared memory port; 4 cycles per ALU op, 5 per lw at zero wait.
// Memory wait states stall the FSM with request, address and data held; ebreak or illegal code halts until reset.
module riscv_mc #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          NREGS    = 32,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    riscv_mc_if.master       mem,
    output logic             done,
    output logic [CNT_W-1:0] retired
);
    localparam int          RW    = (NREGS == 16) ? 4 : 5;
    localparam logic [31:0] AMASK = (ADDR_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ADDR_W) - 32'd1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEMADR, S_MEMRD, S_MEMWR,
        S_BRANCH, S_JAL, S_JALR, S_WB, S_HALT
    } state_t;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT} alu_t;

    state_t            state, state_n;
    logic [31:0]       pc, pc_n, old_pc, ir, a, b, alu_out, mdr;
    logic [31:0]       rf [NREGS];
    logic              req_q, we_q, req_n, we_n, done_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [31:0]       wdata_q, wdata_n;
    logic              xfer, hold;

    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, rs1_val, rs2_val;
    logic        is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui, bad_reg;

    assign xfer   = req_q && mem.ready;
    assign hold   = req_q && !mem.ready;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    always_comb begin
        is_r    = (opcode == 7'b0110011) &&
                  ((f7 == 7'b0000000 && f3 != 3'b001 && f3 != 3'b011 && f3 != 3'b100 && f3 != 3'b101) ||
                   (f7 == 7'b0100000 && f3 == 3'b000));
        is_i    = (opcode == 7'b0010011) && f3 != 3'b001 && f3 != 3'b011 && f3 != 3'b101;
        is_lw   = (opcode == 7'b0000011) && f3 == 3'b010;
        is_sw   = (opcode == 7'b0100011) && f3 == 3'b010;
        is_br   = (opcode == 7'b1100011) && !f3[1];
        is_jal  = (opcode == 7'b1101111);
        is_jalr = (opcode == 7'b1100111) && f3 == 3'b000;
        is_lui  = (opcode == 7'b0110111);
        // RV32E only has x0..x15: any used register field with bit 4 set is illegal
        bad_reg = (NREGS == 16) &&
                  (((is_r || is_i || is_lw || is_sw || is_br || is_jalr) && rs1[4]) ||
                   ((is_r || is_sw || is_br) && rs2[4]) ||
                   ((is_r || is_i || is_lw || is_jal || is_jalr || is_lui) && rd[4]));
        case (opcode)
            7'b0100011: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            7'b1100011: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            7'b1101111: imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            7'b0110111: imm = {ir[31:12], 12'd0};
            default:    imm = {{20{ir[31]}}, ir[31:20]};
        endcase
    end

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1[RW-1:0]];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2[RW-1:0]];

    logic [31:0] alu_a, alu_b, alu_y;
    alu_t        alu_sel;
    logic        taken;

    always_comb begin
        alu_a   = a;
        alu_b   = imm;
        alu_sel = ALU_ADD;
        case (state)
            S_EXEC: begin
                alu_b = is_r ? b : imm;
                case (f3)
                    3'b000:  alu_sel = (is_r && f7[5]) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_sel = ALU_SLT;
                    3'b100:  alu_sel = ALU_XOR;
                    3'b110:  alu_sel = ALU_OR;
                    3'b111:  alu_sel = ALU_AND;
                    default: alu_sel = ALU_ADD;
                endcase
            end
            S_BRANCH: begin
                alu_b   = b;
                alu_sel = f3[2] ? ALU_SLT : ALU_SUB;
            end
            S_JAL:   alu_a = old_pc;
            default: alu_a = a;
        endcase
        case (alu_sel)
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_XOR: alu_y = alu_a ^ alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = alu_a + alu_b;
        endcase
        case (f3)
            3'b000:  taken = (alu_y == 32'd0);
            3'b001:  taken = (alu_y != 32'd0);
            3'b100:  taken = alu_y[0];
            default: taken = !alu_y[0];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_FETCH:  if (xfer) state_n = S_DECODE;
            S_DECODE: begin
                if (bad_reg)                   state_n = S_HALT;
                else if (is_r || is_i)         state_n = S_EXEC;
                else if (is_lw || is_sw)       state_n = S_MEMADR;
                else if (is_br)                state_n = S_BRANCH;
                else if (is_jal)               state_n = S_JAL;
                else if (is_jalr)              state_n = S_JALR;
                else if (is_lui)               state_n = S_WB;
                else                           state_n = S_HALT;
            end
            S_EXEC:   state_n = S_WB;
            S_MEMADR: state_n = is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (xfer) state_n = S_WB;
            S_MEMWR:  if (xfer) state_n = S_FETCH;
            S_BRANCH, S_JAL, S_JALR, S_WB: state_n = S_FETCH;
            default:  state_n = S_HALT;
        endcase
    end

    logic        rf_we;
    logic [31:0] rf_wd;

    always_comb begin
        pc_n = pc;
        case (state)
            S_FETCH:  if (xfer) pc_n = pc + 32'd4;
            S_BRANCH: if (taken) pc_n = old_pc + imm;
            S_JAL:    pc_n = alu_y;
            S_JALR:   pc_n = alu_y & ~32'd1;
            default:  pc_n = pc;
        endcase
        pc_n = pc_n & AMASK;

        // Outputs are registered from the next state so a new access starts on the transition edge
        req_n   = req_q;
        we_n    = we_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        if (!hold) begin
            req_n = (state_n == S_FETCH) || (state_n == S_MEMRD) || (state_n == S_MEMWR);
            we_n  = (state_n == S_MEMWR);
            if (state_n == S_FETCH)
                addr_n = {pc_n[ADDR_W-1:2], 2'b00};
            else if (state_n == S_MEMRD || state_n == S_MEMWR)
                addr_n = {alu_y[ADDR_W-1:2], 2'b00};
            if (state_n == S_MEMWR)
                wdata_n = b;
        end
        done_n = (state_n == S_HALT);

        rf_we = (state == S_WB || state == S_JAL || state == S_JALR) && (rd != 5'd0);
        if (state == S_JAL || state == S_JALR) rf_wd = pc;
        else if (is_lw)                        rf_wd = mdr;
        else if (is_lui)                       rf_wd = imm;
        else                                   rf_wd = alu_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC & AMASK;
            old_pc  <= 32'd0;
            ir      <= 32'd0;
            a       <= 32'd0;
            b       <= 32'd0;
            alu_out <= 32'd0;
            mdr     <= 32'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            done    <= 1'b0;
            retired <= '0;
        end else begin
            pc      <= pc_n;
            req_q   <= req_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            done    <= done_n;
            if (state != S_FETCH && state_n == S_FETCH) retired <= retired + CNT_W'(1);
            if (state == S_FETCH && xfer) begin
                ir     <= mem.rdata;
                old_pc <= pc;
            end
            if (state == S_DECODE) begin
                a <= rs1_val;
                b <= rs2_val;
            end
            if (state == S_EXEC || state == S_MEMADR) alu_out <= alu_y;
            if (state == S_MEMRD && xfer) mdr <= mem.rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we) rf[rd[RW-1:0]] <= rf_wd;
    end

    assign mem.req   = req_q;
    assign mem.we    = we_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;
endmodule

// File: tb/tb_riscv_mc.sv
// Directed bench for riscv_mc: RV32I and RV32E instances share one wait-state memory model selected by sel.
module tb_riscv_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1, rst1 = 1'b1, sel = 1'b0;
    logic        done0, done1;
    logic [31:0] ret0, ret1;
    int          n_checks = 0, n_pass = 0;

    riscv_mc_if #(.ADDR_W(32)) bus0 ();
    riscv_mc_if #(.ADDR_W(32)) bus1 ();

    riscv_mc #(.ADDR_W(32), .RESET_PC(32'h0), .NREGS(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst0), .mem(bus0), .done(done0), .retired(ret0));
    riscv_mc #(.ADDR_W(32), .RESET_PC(32'h0), .NREGS(16), .CNT_W(32)) dut16 (
        .clk(clk), .rst(rst1), .mem(bus1), .done(done1), .retired(ret1));

    logic        m_req, m_we, m_ready, cur_done;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [31:0] mem [0:255];
    int          wait_cyc = 0, wcnt = 0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = 32'd0, ld_data = 32'd0;

    assign m_req      = sel ? bus1.req   : bus0.req;
    assign m_we       = sel ? bus1.we    : bus0.we;
    assign m_addr     = sel ? bus1.addr  : bus0.addr;
    assign m_wdata    = sel ? bus1.wdata : bus0.wdata;
    assign m_ready    = m_req && (wcnt >= wait_cyc);
    assign m_rdata    = mem[m_addr[9:2]];
    assign bus0.ready = !sel && m_ready;
    assign bus1.ready = sel && m_ready;
    assign bus0.rdata = m_rdata;
    assign bus1.rdata = m_rdata;
    assign cur_done   = sel ? done1 : done0;

    always @(posedge clk) begin
        if (!m_req || m_ready) wcnt <= 0;
        else                   wcnt <= wcnt + 1;
        if (ld_en)                         mem[ld_addr[9:2]] <= ld_data;
        else if (m_req && m_ready && m_we) mem[m_addr[9:2]]  <= m_wdata;
    end

    // Bus monitor: handshake stability, write count, accesses at address 8, read-completion log
    logic        mon_clr = 1'b0, p_pend = 1'b0, p_req = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = 32'd0, p_wdata = 32'd0;
    int          unstable = 0, wr_cnt = 0, a8_cnt = 0, nfetch = 0;
    logic [31:0] flog [16];

    always @(negedge clk) begin
        if (mon_clr) begin
            unstable <= 0; wr_cnt <= 0; a8_cnt <= 0; nfetch <= 0; p_pend <= 1'b0;
        end else begin
            if (p_pend && (m_req !== p_req || m_we !== p_we || m_addr !== p_addr || m_wdata !== p_wdata))
                unstable <= unstable + 1;
            p_pend <= m_req && !m_ready;
            p_req <= m_req; p_we <= m_we; p_addr <= m_addr; p_wdata <= m_wdata;
            if (m_req && m_ready && m_we) wr_cnt <= wr_cnt + 1;
            if (m_req && m_ready && !m_we && nfetch < 16) begin
                flog[nfetch[3:0]] <= m_addr;
                nfetch <= nfetch + 1;
            end
            if (m_req && m_addr == 32'd8) a8_cnt <= a8_cnt + 1;
        end
    end

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    task automatic poke(input logic [31:0] ad, input logic [31:0] d);
        @(negedge clk);
        ld_addr = ad; ld_data = d; ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic clr_mon();
        @(negedge clk); #1 mon_clr = 1'b1;
        @(negedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic hold_reset(input logic s, input int w);
        rst0 = 1'b0; rst1 = 1'b0; sel = s; wait_cyc = w;
    endtask

    task automatic release_rst();
        @(negedge clk); #1;
        if (sel) rst1 = 1'b1; else rst0 = 1'b1;
    endtask

    task automatic run_to_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cur_done === 1'b1) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) $display("FAIL %s_done: done never rose within 2000 cycles", name); else n_pass++;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; sel = 1'b0; wait_cyc = 0;
        #2 rst0 = 1'b0; rst1 = 1'b0;
        #1;
        n_checks++; if (bus0.req !== 1'b0) $display("FAIL rst_req got %b want 0", bus0.req); else n_pass++;
        n_checks++; if (bus0.we !== 1'b0) $display("FAIL rst_we got %b want 0", bus0.we); else n_pass++;
        n_checks++; if (bus0.addr !== 32'd0) $display("FAIL rst_addr got %h want 0", bus0.addr); else n_pass++;
        n_checks++; if (bus0.wdata !== 32'd0) $display("FAIL rst_wdata got %h want 0", bus0.wdata); else n_pass++;
        n_checks++; if (done0 !== 1'b0) $display("FAIL rst_done got %b want 0", done0); else n_pass++;
        n_checks++; if (ret0 !== 32'd0) $display("FAIL rst_retired got %0d want 0", ret0); else n_pass++;
        poke(32'h0, EBREAK);
        clr_mon();
        release_rst();
        @(negedge clk);
        n_checks++; if (bus0.req !== 1'b1 || bus0.we !== 1'b0 || bus0.addr !== 32'd0)
            $display("FAIL first_fetch got req=%b we=%b addr=%h want 1 0 00000000", bus0.req, bus0.we, bus0.addr); else n_pass++;
        run_to_done("ebreak");
        n_checks++; if (ret0 !== 32'd0) $display("FAIL ebreak_retired got %0d want 0", ret0); else n_pass++;
    endtask

    task automatic test_alu();
        hold_reset(1'b0, 0);
        poke(32'h0, 32'h0050_0093);   // addi x1,x0,5
        poke(32'h4, 32'hFFD0_0113);   // addi x2,x0,-3
        poke(32'h8, 32'h0020_81B3);   // add  x3,x1,x2
        poke(32'hC, EBREAK);
        clr_mon();
        release_rst();
        run_to_done("alu");
        n_checks++; if (dut.rf[1] !== 32'd5) $display("FAIL alu_x1 got %h want 00000005", dut.rf[1]); else n_pass++;
        n_checks++; if (dut.rf[2] !== 32'hFFFF_FFFD) $display("FAIL alu_x2 got %h want fffffffd", dut.rf[2]); else n_pass++;
        n_checks++; if (dut.rf[3] !== 32'd2) $display("FAIL alu_x3 got %h want 00000002", dut.rf[3]); else n_pass++;
        n_checks++; if (ret0 !== 32'd3) $display("FAIL alu_retired got %0d want 3", ret0); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus0.req !== 1'b0) $display("FAIL halt_req got %b want 0", bus0.req); else n_pass++;
    endtask

    task automatic test_mem_wait();
        hold_reset(1'b0, 3);
        poke(32'h0,  enc_j(32'h40, 5'd0));
        poke(32'h8,  32'h0);
        poke(32'h40, enc_i(32'd5, 5'd0, 3'b000, 5'd1, 7'b0010011));
        poke(32'h44, enc_s(32'd8, 5'd1, 5'd0));
        poke(32'h48, enc_i(32'd8, 5'd0, 3'b010, 5'd4, 7'b0000011));
        poke(32'h4C, EBREAK);
        clr_mon();
        release_rst();
        run_to_done("mem");
        n_checks++; if (dut.rf[4] !== 32'd5) $display("FAIL mem_x4 got %h want 00000005", dut.rf[4]); else n_pass++;
        n_checks++; if (mem[2] !== 32'd5) $display("FAIL mem_word8 got %h want 00000005", mem[2]); else n_pass++;
        n_checks++; if (wr_cnt !== 1) $display("FAIL mem_writes got %0d want 1", wr_cnt); else n_pass++;
        n_checks++; if (unstable !== 0) $display("FAIL mem_stable got %0d changes want 0", unstable); else n_pass++;
        n_checks++; if (a8_cnt !== 8) $display("FAIL mem_addr8_cycles got %0d want 8", a8_cnt); else n_pass++;
        n_checks++; if (ret0 !== 32'd4) $display("FAIL mem_retired got %0d want 4", ret0); else n_pass++;
    endtask

    task automatic test_branch();
        logic [31:0] exp_f [6];
        exp_f = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h14, 32'h18};
        hold_reset(1'b0, 1);
        poke(32'h0,  enc_i(32'd5, 5'd0, 3'b000, 5'd1, 7'b0010011));
        poke(32'h4,  enc_i(32'hFFFF_FFFD, 5'd0, 3'b000, 5'd2, 7'b0010011));
        poke(32'h8,  enc_b(32'd8, 5'd1, 5'd2, 3'b100));   // blt x2,x1,+8
        poke(32'hC,  EBREAK);
        poke(32'h10, enc_b(32'd8, 5'd1, 5'd2, 3'b101));   // bge x2,x1,+8
        poke(32'h14, enc_i(32'd7, 5'd0, 3'b000, 5'd5, 7'b0010011));
        poke(32'h18, EBREAK);
        poke(32'h1C, EBREAK);
        clr_mon();
        release_rst();
        run_to_done("branch");
        n_checks++; if (nfetch !== 6) $display("FAIL br_nfetch got %0d want 6", nfetch); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (flog[i] !== exp_f[i]) $display("FAIL br_pc%0d got %h want %h", i, flog[i], exp_f[i]); else n_pass++;
        end
        n_checks++; if (dut.rf[5] !== 32'd7) $display("FAIL br_x5 got %h want 00000007", dut.rf[5]); else n_pass++;
        n_checks++; if (ret0 !== 32'd5) $display("FAIL br_retired got %0d want 5", ret0); else n_pass++;
    endtask

    task automatic test_jump();
        logic [31:0] exp_f [4];
        exp_f = '{32'h0, 32'h40, 32'h50, 32'h44};
        hold_reset(1'b0, 0);
        poke(32'h0,  enc_j(32'h40, 5'd0));
        poke(32'h40, enc_j(32'd16, 5'd1));
        poke(32'h44, EBREAK);
        poke(32'h50, enc_i(32'd1, 5'd1, 3'b000, 5'd0, 7'b1100111));   // jalr x0,1(x1)
        clr_mon();
        release_rst();
        run_to_done("jump");
        n_checks++; if (nfetch !== 4) $display("FAIL jmp_nfetch got %0d want 4", nfetch); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (flog[i] !== exp_f[i]) $display("FAIL jmp_pc%0d got %h want %h", i, flog[i], exp_f[i]); else n_pass++;
        end
        n_checks++; if (dut.rf[1] !== 32'h44) $display("FAIL jmp_x1 got %h want 00000044", dut.rf[1]); else n_pass++;
        n_checks++; if (ret0 !== 32'd3) $display("FAIL jmp_retired got %0d want 3", ret0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        hold_reset(1'b0, 5);
        poke(32'h0,  enc_j(32'h40, 5'd0));
        poke(32'h8,  32'h1234_5678);
        poke(32'h40, enc_i(32'd8, 5'd0, 3'b010, 5'd4, 7'b0000011));
        poke(32'h44, EBREAK);
        clr_mon();
        release_rst();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (m_req === 1'b1 && m_we === 1'b0 && m_addr === 32'd8) begin found = 1'b1; break; end
        end
        n_checks++; if (!found) $display("FAIL rmid_load_seen: no load at 8 within 300 cycles"); else n_pass++;
        @(negedge clk); @(negedge clk);
        n_checks++; if (ret0 !== 32'd1) $display("FAIL rmid_pre_retired got %0d want 1", ret0); else n_pass++;
        #1 rst0 = 1'b0;
        #1;
        n_checks++; if (bus0.req !== 1'b0) $display("FAIL rmid_req got %b want 0", bus0.req); else n_pass++;
        n_checks++; if (bus0.addr !== 32'd0) $display("FAIL rmid_addr got %h want 0", bus0.addr); else n_pass++;
        n_checks++; if (ret0 !== 32'd0) $display("FAIL rmid_retired got %0d want 0", ret0); else n_pass++;
        clr_mon();
        release_rst();
        run_to_done("rmid");
        n_checks++; if (flog[0] !== 32'h0) $display("FAIL rmid_first_fetch got %h want 00000000", flog[0]); else n_pass++;
        n_checks++; if (dut.rf[4] !== 32'h1234_5678) $display("FAIL rmid_x4 got %h want 12345678", dut.rf[4]); else n_pass++;
        n_checks++; if (ret0 !== 32'd2) $display("FAIL rmid_post_retired got %0d want 2", ret0); else n_pass++;
    endtask

    task automatic test_rv32e();
        hold_reset(1'b1, 0);
        poke(32'h0, enc_i(32'd5, 5'd0, 3'b000, 5'd1, 7'b0010011));
        poke(32'h4, enc_i(32'd6, 5'd0, 3'b000, 5'd2, 7'b0010011));
        poke(32'h8, enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd17));   // add x17,x1,x2
        poke(32'hC, EBREAK);
        clr_mon();
        release_rst();
        run_to_done("rv32e");
        n_checks++; if (ret1 !== 32'd2) $display("FAIL e_retired got %0d want 2", ret1); else n_pass++;
        n_checks++; if (nfetch !== 3) $display("FAIL e_nfetch got %0d want 3", nfetch); else n_pass++;
        n_checks++; if (wr_cnt !== 0) $display("FAIL e_writes got %0d want 0", wr_cnt); else n_pass++;
        n_checks++; if (dut16.rf[1] !== 32'd5) $display("FAIL e_x1 got %h want 00000005", dut16.rf[1]); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus1.req !== 1'b0) $display("FAIL e_halt_req got %b want 0", bus1.req); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem_wait();
        test_branch();
        test_jump();
        test_reset_mid();
        test_rv32e();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
